// File: rtl/fifo_rr_drain_arb.sv
// fifo_rr_drain_arb: round-robin burst drain of NCH FIFO read ports into a 2-entry valid/ready output buffer.
// Define ARB_BEAT_CNT_EN to add per-channel delivered-word counters on beat_cnt_o.
module fifo_rr_drain_arb #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4,
    parameter int unsigned CHW   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH-1:0]       ch_en_i,
    input  logic [NCH-1:0]       empty_i,
    input  logic [NCH*WIDTH-1:0] rdata_i,
    output logic [NCH-1:0]       rd_en_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [CHW-1:0]       out_ch_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
`ifdef ARB_BEAT_CNT_EN
    ,
    output logic [NCH*16-1:0]    beat_cnt_o
`endif
);
    localparam int unsigned    BW        = 4;
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BURST - 1);
    localparam logic [CHW-1:0] RR_INIT   = CHW'(NCH - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;
    state_t state_q, state_d;

    logic [CHW-1:0]   grant_q, rr_q, pick_ch, inflight_ch_q;
    logic [BW-1:0]    beats_q;
    logic [NCH-1:0]   req;
    logic             pick_found, grant_ok, credit_ok, issue, pop, inflight_q;
    logic [WIDTH-1:0] push_data, s_data_q, out_data_d, s_data_d;
    logic [CHW-1:0]   s_ch_q, out_ch_d, s_ch_d;
    logic             s_valid_q, out_valid_d, s_valid_d;

    assign req      = ch_en_i & ~empty_i;
    assign grant_ok = ch_en_i[grant_q] & ~empty_i[grant_q];
    assign pop      = out_valid_o & out_ready_i;
    // Held words plus the outstanding read must leave room after this cycle's pop.
    assign credit_ok = (3'(out_valid_o) + 3'(s_valid_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
    assign issue     = (state_q == ST_BURST) & grant_ok & credit_ok & ~rst_i;
    assign busy_o    = (state_q == ST_BURST) | inflight_q;

    // First requesting channel after the last granted one, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            if (!pick_found && req[CHW'((32'(rr_q) + i) % NCH)]) begin
                pick_found = 1'b1;
                pick_ch    = CHW'((32'(rr_q) + i) % NCH);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_BURST;
            ST_BURST: begin
                if (!grant_ok)                            state_d = ST_IDLE;
                else if (issue && (beats_q == BEAT_LAST)) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en_o = '0;
        if (issue) rd_en_o[grant_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q       <= '0;
            rr_q          <= RR_INIT;
            beats_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_ch_q <= '0;
        end else begin
            inflight_q    <= issue;
            inflight_ch_q <= grant_q;
            if ((state_q == ST_IDLE) && pick_found) begin
                grant_q <= pick_ch;
                beats_q <= '0;
            end else if (issue) begin
                beats_q <= beats_q + BW'(1);
            end
            if ((state_q == ST_BURST) && (state_d == ST_IDLE)) rr_q <= grant_q;
        end
    end

    always_comb begin
        push_data = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (inflight_ch_q == CHW'(c)) push_data = rdata_i[c*WIDTH +: WIDTH];
        end
    end

    // Two-slot buffer: pop shifts the second slot to the head, then the arriving word fills the first free slot.
    always_comb begin
        out_data_d  = out_data_o;
        out_ch_d    = out_ch_o;
        out_valid_d = out_valid_o;
        s_data_d    = s_data_q;
        s_ch_d      = s_ch_q;
        s_valid_d   = s_valid_q;
        if (pop) begin
            out_data_d  = s_data_q;
            out_ch_d    = s_ch_q;
            out_valid_d = s_valid_q;
            s_valid_d   = 1'b0;
        end
        if (inflight_q) begin
            if (!out_valid_d) begin
                out_data_d  = push_data;
                out_ch_d    = inflight_ch_q;
                out_valid_d = 1'b1;
            end else begin
                s_data_d  = push_data;
                s_ch_d    = inflight_ch_q;
                s_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_data_o  <= '0;
            out_ch_o    <= '0;
            out_valid_o <= 1'b0;
            s_data_q    <= '0;
            s_ch_q      <= '0;
            s_valid_q   <= 1'b0;
        end else begin
            out_data_o  <= out_data_d;
            out_ch_o    <= out_ch_d;
            out_valid_o <= out_valid_d;
            s_data_q    <= s_data_d;
            s_ch_q      <= s_ch_d;
            s_valid_q   <= s_valid_d;
        end
    end

`ifdef ARB_BEAT_CNT_EN
    logic [15:0] cnt_q [NCH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NCH; c++) cnt_q[c] <= '0;
        end else if (pop && (cnt_q[out_ch_o] != 16'hFFFF)) begin
            cnt_q[out_ch_o] <= cnt_q[out_ch_o] + 16'd1;
        end
    end

    for (genvar gc = 0; gc < NCH; gc++) begin : g_cnt
        assign beat_cnt_o[gc*16 +: 16] = cnt_q[gc];
    end
`endif
endmodule
